// File: rtl/fetch_queue_pkg.sv
// Shared widths, reset fetch vector and queue entry type for the fetch front end.
package fetch_queue_pkg;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int FQ_DEPTH = 2;

  localparam logic [ADDR_W-1:0] RESET_VEC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// ROM read port, redirect input and decode handshake of the fetch front end.
interface fetch_queue_if import fetch_queue_pkg::*; ();
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  modport master (
    input  redirect, redirect_addr, rom_data, out_ready,
    output rom_req, rom_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect, redirect_addr, rom_data, out_ready,
    input  rom_req, rom_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO with push, pop, synchronous flush and occupancy count.
module fetch_fifo import fetch_queue_pkg::*; #(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  fq_entry_t     i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fq_entry_t     o_head,
  output logic [CW-1:0] o_count
);
  fq_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_rd;
  logic [AW-1:0]     r_wr;
  logic [CW-1:0]     r_cnt;

  // Flush drops pointers only; stale storage is hidden behind a zero count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: fetch pointer, ROM issue, prefetch queue, redirect flush.
// Optional FETCH_STALL_CNT_EN adds o_stall_count (decode-ready-but-empty cycles).
module fetch_queue import fetch_queue_pkg::*; #(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0] o_stall_count,
`endif
  fetch_queue_if.master fq
);
  logic              r_run;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [ADDR_W-1:0] r_fpc;
  logic [CW-1:0]     w_count;
  fq_entry_t         w_head;
  fq_entry_t         w_wdata;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_push;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & fq.out_ready;
  // r_run holds off issue until the first full cycle after reset release.
  assign w_issue = r_run & ~fq.redirect &
                   ((int'(w_count) + int'(r_inflight) - int'(w_pop)) < DEPTH);
  // A response landing in a redirect cycle is stale; flush also wins inside the FIFO.
  assign w_push  = r_inflight & ~fq.redirect;
  assign w_wdata = '{pc: r_inflight_pc, instr: fq.rom_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run         <= 1'b0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_fpc         <= RESET_VEC;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fpc;
      if (fq.redirect)  r_fpc <= fq.redirect_addr;
      else if (w_issue) r_fpc <= r_fpc + 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .i_flush (fq.redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fq.rom_req   = w_issue;
  assign fq.rom_addr  = r_fpc;
  assign fq.out_valid = w_valid;
  assign fq.out_instr = w_head.instr;
  assign fq.out_pc    = w_head.pc;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_stall_cnt <= '0;
    else if (fq.out_ready && !w_valid && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: ROM model returns 0x1000+addr, expected {pc,instr} queued at stimulus.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_if fq ();
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall;
`endif

  fetch_queue dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
`ifdef FETCH_STALL_CNT_EN
    .o_stall_count (stall),
`endif
    .fq            (fq)
  );

  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    return 16'h1000 + a;
  endfunction

  // ROM: fixed one-cycle read latency
  always @(posedge clk) fq.rom_data <= rom_val(fq.rom_addr);

  int errs = 0, checks = 0;
  int cyc_n = 0, t_first = -1, t_last = -1;
  fq_entry_t sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [ADDR_W-1:0] start, input int n);
    fq_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + ADDR_W'(i);
      e.instr = rom_val(e.pc);
      sb.push_back(e);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #2;
    cyc_n++;
  endtask

  task automatic mon();
    fq_entry_t e;
    #1;
    if (fq.out_valid && t_first < 0) t_first = cyc_n;
    if (fq.out_valid && fq.out_ready) begin
      if (sb.size() == 0) chk("unexpected_xfer", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("xfer_pc", 32'(fq.out_pc), 32'(e.pc));
        chk("xfer_instr", 32'(fq.out_instr), 32'(e.instr));
        t_last = cyc_n;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      edge_();
      fq.out_ready = 1'b1;
      fq.redirect  = 1'b0;
      mon();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic chk_rst();
    chk("rst_rom_req", 32'(fq.rom_req), 0);
    chk("rst_rom_addr", 32'(fq.rom_addr), 0);
    chk("rst_out_valid", 32'(fq.out_valid), 0);
    chk("rst_out_instr", 32'(fq.out_instr), 0);
    chk("rst_out_pc", 32'(fq.out_pc), 0);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall), 0);
`endif
  endtask

  // Release reset mid-cycle with decode ready; expects n in-order instructions from address 0.
  task automatic release_reset(input int n);
    int t0;
    push_seq(16'h0000, n);
    edge_();
    rst_n        = 1'b1;
    fq.out_ready = 1'b1;
    fq.redirect  = 1'b0;
    t_first      = -1;
    t0           = cyc_n;
    mon();
    chk("c0_rom_req", 32'(fq.rom_req), 0);
    edge_();
    mon();
    chk("c1_rom_req", 32'(fq.rom_req), 1);
    chk("c1_rom_addr", 32'(fq.rom_addr), 0);
    drain(40);
    chk("first_valid_cycle", 32'(t_first - t0), 3);
    chk("startup_steady", 32'(t_last - t_first), 32'(n - 1));
`ifdef FETCH_STALL_CNT_EN
    chk("startup_stall_cnt", 32'(stall), 3);
`endif
  endtask

  initial begin
    int  ts, t0, n;
    logic any_req, stable, hit;
    rst_n            = 1'b0;
    fq.redirect      = 1'b0;
    fq.redirect_addr = '0;
    fq.out_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_rst();

    release_reset(8);

    // Stall with decode not ready: queue fills, no issue, head holds
    push_seq(16'h0008, 8);
    any_req = 1'b0;
    stable  = 1'b1;
    repeat (10) begin
      edge_();
      fq.out_ready = 1'b0;
      mon();
      any_req |= fq.rom_req;
      if (!(fq.out_valid && fq.out_pc == 16'h0008)) stable = 1'b0;
    end
    chk("stall_rom_req", 32'(any_req), 0);
    chk("stall_head_stable", 32'(stable), 1);
    edge_();
    fq.out_ready = 1'b1;
    ts = cyc_n;
    mon();
    chk("resume_rom_req", 32'(fq.rom_req), 1);
    drain(40);
    chk("resume_steady", 32'(t_last - ts), 7);

    // Redirect with one queued and one arriving
    push_seq(16'h0040, 4);
    edge_();
    fq.out_ready     = 1'b0;
    fq.redirect      = 1'b1;
    fq.redirect_addr = 16'h0040;
    t0 = cyc_n;
    mon();
    chk("redir_t_rom_req", 32'(fq.rom_req), 0);
    edge_();
    fq.redirect  = 1'b0;
    fq.out_ready = 1'b1;
    t_first      = -1;
    mon();
    chk("redir_t1_rom_req", 32'(fq.rom_req), 1);
    chk("redir_t1_rom_addr", 32'(fq.rom_addr), 32'h0040);
    drain(20);
    chk("redir_latency", 32'(t_first - t0), 3);

    // Redirect in the same cycle pc 5 transfers
    push_seq(16'h0003, 3);
    edge_();
    fq.out_ready     = 1'b0;
    fq.redirect      = 1'b1;
    fq.redirect_addr = 16'h0003;
    mon();
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 20) begin
      edge_();
      fq.out_ready = 1'b1;
      fq.redirect  = 1'b0;
      if (fq.out_valid && fq.out_pc == 16'h0005) begin
        fq.redirect      = 1'b1;
        fq.redirect_addr = 16'h0100;
        push_seq(16'h0100, 4);
        hit = 1'b1;
      end
      mon();
      n++;
    end
    chk("redir_xfer_seen", 32'(hit), 1);
    drain(20);

    // Address wrap
    push_seq(16'hFFFE, 4);
    edge_();
    fq.out_ready     = 1'b0;
    fq.redirect      = 1'b1;
    fq.redirect_addr = 16'hFFFE;
    mon();
    drain(20);

    // Asynchronous reset mid-stream
    edge_();
    fq.out_ready = 1'b0;
    mon();
    chk("pre_rst_valid", 32'(fq.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_rst();
    repeat (2) edge_();
    release_reset(4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
